// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives imem_pc and buffers {pc, instr} in a small FIFO toward decode.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect targets raise a sticky fault instead of being truncated.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] PC_LIMIT   = 32'd96
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        halted,
    output logic        fault
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, FAULT = 2'd2} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_t           state, state_nxt;
    logic [31:0]      pc;
    fetch_ent_t       fifo [FIFO_DEPTH];
    fetch_ent_t       head;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             pop, push, fifo_full, redir_bad;
    logic [31:0]      redir_tgt;

    // Without the alignment check the low target bits are simply dropped.
    assign redir_bad = ALIGN_CHK && (redirect_pc[1:0] != 2'b00);
    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = id_valid & id_ready;
    assign push      = (state == RUN) & (pc < PC_LIMIT) & ~redirect_valid & (~fifo_full | pop);
    assign imem_pc   = pc;

    // A redirect flushes the buffer and wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (!redir_bad) pc <= redir_tgt;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc     <= pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; the outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {pc, imem_instr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            if (redir_bad)                  state_nxt = FAULT;
            else if (redir_tgt >= PC_LIMIT) state_nxt = HALT;
            else                            state_nxt = RUN;
        end else if (state == RUN && pc >= PC_LIMIT) begin
            state_nxt = HALT;
        end
    end

    always_comb begin
        head        = fifo[rd_ptr];
        id_valid    = (count != '0);
        id_pc       = id_valid ? head.pc : 32'h0;
        id_instr    = id_valid ? head.instr : 32'h0;
        id_pc_plus4 = id_pc + 32'd4;
        halted      = (state == HALT);
        fault       = ALIGN_CHK && (state == FAULT);
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a word-array instruction memory feeds the DUT and
// expected {pc, instr} pairs are queued as fetch is started and compared as decode pops them.
module tb_instr_fetch_unit;
    localparam int MEM_WORDS = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc, imem_instr, redirect_pc;
    logic        redirect_valid, id_valid, id_ready, halted, fault;
    logic [31:0] id_pc, id_instr, id_pc_plus4;

    logic [31:0] mem [MEM_WORDS];
    logic [63:0] sb_q [$];
    logic [63:0] exp;
    int checks = 0;
    int failures = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < 32'(MEM_WORDS * 4)) ? mem[imem_pc[6:2]] : 32'h0;

    function automatic logic [63:0] sb_ent(input logic [31:0] p);
        return {p, mem[p[6:2]]};
    endfunction

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = rdy;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h4 ||
            halted !== 1'b0 || fault !== 1'b0 || imem_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got v=%b pc=%h instr=%h p4=%h h=%b f=%b imem_pc=%h exp 0/0/0/4/0/0/0",
                     id_valid, id_pc, id_instr, id_pc_plus4, halted, fault, imem_pc);
        end
    endtask

    task automatic test_stream;
        int first_cyc = -1;
        do_reset(1'b1);
        for (int a = 0; a < 24; a += 4) sb_q.push_back(sb_ent(32'(a)));
        for (int cyc = 0; cyc < 40 && sb_q.size() > 0; cyc++) begin
            if (first_cyc >= 0) begin
                checks++;
                if (id_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_gap got id_valid=%b exp 1 at cycle %0d", id_valid, cyc);
                end
            end
            if (id_valid && id_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                exp = sb_q.pop_front();
                checks++;
                if ({id_pc, id_instr} !== exp || id_pc_plus4 !== exp[63:32] + 32'd4) begin
                    failures++;
                    $display("FAIL stream_entry got pc=%h instr=%h p4=%h exp pc=%h instr=%h",
                             id_pc, id_instr, id_pc_plus4, exp[63:32], exp[31:0]);
                end
            end
            if (sb_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0 || first_cyc != 1) begin
            failures++;
            $display("FAIL stream_latency got first_valid_cycle=%0d left=%0d exp 1 and 0", first_cyc, sb_q.size());
        end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_pc !== 32'h8) begin
            failures++;
            $display("FAIL stall_full got v=%b id_pc=%h imem_pc=%h exp 1 0 8", id_valid, id_pc, imem_pc);
        end
        id_ready = 1'b1;
        for (int a = 0; a < 24; a += 4) sb_q.push_back(sb_ent(32'(a)));
        for (int cyc = 0; cyc < 40 && sb_q.size() > 0; cyc++) begin
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                checks++;
                if ({id_pc, id_instr} !== exp) begin
                    failures++;
                    $display("FAIL stall_drain got pc=%h instr=%h exp pc=%h instr=%h",
                             id_pc, id_instr, exp[63:32], exp[31:0]);
                end
            end
            if (sb_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL stall_timeout got left=%0d exp 0", sb_q.size());
        end
    endtask

    task automatic test_redirect_full;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'd80;
        id_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || imem_pc !== 32'd80) begin
            failures++;
            $display("FAIL redir_flush got v=%b imem_pc=%h exp 0 50", id_valid, imem_pc);
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'd80 || id_instr !== 32'h0041a463) begin
            failures++;
            $display("FAIL redir_target got v=%b pc=%h instr=%h exp 1 50 0041a463", id_valid, id_pc, id_instr);
        end
        for (int a = 80; a < 96; a += 4) sb_q.push_back(sb_ent(32'(a)));
        for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) begin
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                checks++;
                if ({id_pc, id_instr} !== exp) begin
                    failures++;
                    $display("FAIL redir_stream got pc=%h instr=%h exp pc=%h instr=%h",
                             id_pc, id_instr, exp[63:32], exp[31:0]);
                end
            end
            if (sb_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL redir_timeout got left=%0d exp 0", sb_q.size());
        end
    endtask

    task automatic test_halt;
        do_reset(1'b1);
        for (int a = 0; a < 96; a += 4) sb_q.push_back(sb_ent(32'(a)));
        for (int cyc = 0; cyc < 60 && sb_q.size() > 0; cyc++) begin
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                checks++;
                if ({id_pc, id_instr} !== exp || id_pc_plus4 !== exp[63:32] + 32'd4) begin
                    failures++;
                    $display("FAIL halt_stream got pc=%h instr=%h p4=%h exp pc=%h instr=%h",
                             id_pc, id_instr, id_pc_plus4, exp[63:32], exp[31:0]);
                end
            end
            if (sb_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0 || id_pc !== 32'd92 || id_instr !== 32'h000080ef) begin
            failures++;
            $display("FAIL halt_last got pc=%h instr=%h left=%0d exp 5c 000080ef 0", id_pc, id_instr, sb_q.size());
        end
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || id_valid !== 1'b0 || imem_pc !== 32'd96) begin
            failures++;
            $display("FAIL halt_state got h=%b v=%b imem_pc=%h exp 1 0 60", halted, id_valid, imem_pc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || id_valid !== 1'b0 || imem_pc !== 32'd96) begin
            failures++;
            $display("FAIL halt_hold got h=%b v=%b imem_pc=%h exp 1 0 60", halted, id_valid, imem_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_release got h=%b exp 0", halted);
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h00940333) begin
            failures++;
            $display("FAIL halt_restart got v=%b pc=%h instr=%h exp 1 0 00940333", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_redirect_limit;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'd200;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || id_valid !== 1'b0 || imem_pc !== 32'd200) begin
            failures++;
            $display("FAIL limit_redirect got h=%b v=%b imem_pc=%h exp 1 0 c8", halted, id_valid, imem_pc);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] held;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        held = imem_pc;
        redirect_valid = 1'b1;
        redirect_pc = 32'h52;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        checks++;
        if (fault !== 1'b1 || id_valid !== 1'b0 || imem_pc !== held) begin
            failures++;
            $display("FAIL misalign_fault got f=%b v=%b imem_pc=%h exp 1 0 %h", fault, id_valid, imem_pc, held);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fault !== 1'b1 || id_valid !== 1'b0 || imem_pc !== held) begin
            failures++;
            $display("FAIL misalign_sticky got f=%b v=%b imem_pc=%h exp 1 0 %h", fault, id_valid, imem_pc, held);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h10) begin
            failures++;
            $display("FAIL misalign_clear got f=%b v=%b pc=%h exp 0 1 10", fault, id_valid, id_pc);
        end
`else
        checks++;
        if (fault !== 1'b0 || id_valid !== 1'b0 || imem_pc !== 32'h50) begin
            failures++;
            $display("FAIL misalign_trunc got f=%b v=%b imem_pc=%h held=%h exp 0 0 50", fault, id_valid, imem_pc, held);
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h50 || id_instr !== 32'h0041a463) begin
            failures++;
            $display("FAIL misalign_fetch got v=%b pc=%h instr=%h exp 1 50 0041a463", id_valid, id_pc, id_instr);
        end
`endif
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h4 ||
            halted !== 1'b0 || fault !== 1'b0 || imem_pc !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b pc=%h instr=%h p4=%h h=%b f=%b imem_pc=%h exp 0/0/0/4/0/0/0",
                     id_valid, id_pc, id_instr, id_pc_plus4, halted, fault, imem_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        sb_q.delete();
        for (int a = 0; a < 12; a += 4) sb_q.push_back(sb_ent(32'(a)));
        for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) begin
            if (id_valid && id_ready) begin
                exp = sb_q.pop_front();
                checks++;
                if ({id_pc, id_instr} !== exp) begin
                    failures++;
                    $display("FAIL restart_stream got pc=%h instr=%h exp pc=%h instr=%h",
                             id_pc, id_instr, exp[63:32], exp[31:0]);
                end
            end
            if (sb_q.size() > 0) @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL restart_timeout got left=%0d exp 0", sb_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0010_0093 + (32'(i) << 7);
        mem[0]  = 32'h00940333;
        mem[1]  = 32'h800100b3;
        mem[20] = 32'h0041a463;
        mem[23] = 32'h000080ef;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_halt();
        test_redirect_limit();
        test_misalign();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
